// File: rtl/freq_div_sequencer_pkg.sv
// Shared definitions for the divider sequencer: state encoding and nibble geometry.
package freq_div_sequencer_pkg;

    localparam int NIBBLE_W  = 4;
    localparam int MIN_RATIO = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        PEND = 2'd3
    } state_t;

endpackage

// File: rtl/freq_div_sequencer_counter.sv
// Reference down-counter mirroring the divider chain: loadable, stops at zero, flags zero.
module div_ref_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/freq_div_sequencer.sv
// Sequencer for the cascaded two-nibble divider: ratio handshake, terminal-count ratio swap,
// preset/load strobes, tick and registered divided output.
module freq_div_sequencer
    import freq_div_sequencer_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int DEF_RATIO = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run_en,
    input  logic [CNT_W-1:0]    cfg_ratio,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic                err_ratio,
    output logic [CNT_W-1:0]    ratio_active,
    output logic                busy,
    output logic                load_pulse,
    output logic [NIBBLE_W-1:0] preset_lo,
    output logic [NIBBLE_W-1:0] preset_hi,
    output logic                cnt_dn,
    output logic                div_tick,
    output logic                div_out
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] ratio_d, pending_q, pending_d;
    logic [CNT_W-1:0] count, load_val, reload_ratio, count_next;
    logic             zero, running, at_tc, xfer, ratio_ok, div_d;

    assign running  = (state_q == RUN) || (state_q == PEND);
    assign at_tc    = running && zero;
    assign xfer     = cfg_valid && cfg_ready;
    assign ratio_ok = (cfg_ratio >= CNT_W'(MIN_RATIO));
    assign load_val = reload_ratio - 1'b1;

    div_ref_counter #(.CNT_W(CNT_W)) u_ref_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load_pulse),
        .load_val (load_val),
        .dec      (running),
        .count    (count),
        .zero     (zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        ratio_d   = ratio_active;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                if (xfer && ratio_ok) ratio_d = cfg_ratio;
                if (run_en) state_d = LOAD;
            end
            LOAD: begin
                state_d = RUN;
                if (xfer && ratio_ok) begin
                    pending_d = cfg_ratio;
                    state_d   = PEND;
                end
            end
            RUN: begin
                // Stopping at terminal count: there is no period left to protect, apply directly.
                if (at_tc && !run_en) begin
                    state_d = IDLE;
                    if (xfer && ratio_ok) ratio_d = cfg_ratio;
                end else if (xfer && ratio_ok) begin
                    pending_d = cfg_ratio;
                    state_d   = PEND;
                end
            end
            PEND: begin
                if (at_tc) begin
                    ratio_d = pending_q;
                    state_d = run_en ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        reload_ratio = ratio_active;
        load_pulse   = 1'b0;
        case (state_q)
            LOAD: load_pulse = 1'b1;
            RUN:  load_pulse = at_tc && run_en;
            PEND: begin
                if (at_tc) reload_ratio = pending_q;
                load_pulse = at_tc && run_en;
            end
            default: load_pulse = 1'b0;
        endcase
        busy      = (state_q != IDLE);
        cnt_dn    = busy;
        cfg_ready = (state_q != PEND);
        div_tick  = at_tc;
        preset_lo = load_val[NIBBLE_W-1:0];
        preset_hi = load_val[2*NIBBLE_W-1:NIBBLE_W];
    end

    // div_out is computed from next-cycle count/ratio so the register lines up with the count.
    always_comb begin
        count_next = count;
        if (load_pulse) begin
            count_next = load_val;
        end else if (running && !zero) begin
            count_next = count - 1'b1;
        end
        div_d = ((state_d == RUN) || (state_d == PEND)) && (count_next >= (ratio_d >> 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ratio_active <= CNT_W'(DEF_RATIO);
            pending_q    <= '0;
            err_ratio    <= 1'b0;
            div_out      <= 1'b0;
        end else begin
            ratio_active <= ratio_d;
            pending_q    <= pending_d;
            err_ratio    <= xfer && !ratio_ok;
            div_out      <= div_d;
        end
    end

endmodule

// File: tb/tb_freq_div_sequencer.sv
// Scoreboard bench for freq_div_sequencer: expected tick/error cycles are queued by the
// stimulus and consumed by a negedge monitor; static outputs are checked inline.
module tb_freq_div_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       run_en;
    logic [7:0] cfg_ratio;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       err_ratio;
    logic [7:0] ratio_active;
    logic       busy;
    logic       load_pulse;
    logic [3:0] preset_lo;
    logic [3:0] preset_hi;
    logic       cnt_dn;
    logic       div_tick;
    logic       div_out;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int exp_tick[$];
    int exp_err[$];

    freq_div_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .run_en       (run_en),
        .cfg_ratio    (cfg_ratio),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .err_ratio    (err_ratio),
        .ratio_active (ratio_active),
        .busy         (busy),
        .load_pulse   (load_pulse),
        .preset_lo    (preset_lo),
        .preset_hi    (preset_hi),
        .cnt_dn       (cnt_dn),
        .div_tick     (div_tick),
        .div_out      (div_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cfg_ready"},    cfg_ready,    1);
        check({tag, "_busy"},         busy,         0);
        check({tag, "_load_pulse"},   load_pulse,   0);
        check({tag, "_div_tick"},     div_tick,     0);
        check({tag, "_div_out"},      div_out,      0);
        check({tag, "_cnt_dn"},       cnt_dn,       0);
        check({tag, "_err_ratio"},    err_ratio,    0);
        check({tag, "_ratio_active"}, ratio_active, 16);
        check({tag, "_preset_hi"},    preset_hi,    0);
        check({tag, "_preset_lo"},    preset_lo,    15);
    endtask

    // Monitor: every tick / error pulse must match the head of its queue; overdue entries fail.
    always @(negedge clk) begin
        if (exp_tick.size() > 0 && exp_tick[0] < cyc) begin
            check("tick_missing", cyc, exp_tick[0]);
            void'(exp_tick.pop_front());
        end
        if (div_tick === 1'b1) begin
            if (exp_tick.size() == 0) begin
                check("tick_unexpected", int'(div_tick), 0);
            end else begin
                check("tick_cycle", cyc, exp_tick[0]);
                if (exp_tick[0] == cyc) void'(exp_tick.pop_front());
            end
        end
        if (exp_err.size() > 0 && exp_err[0] < cyc) begin
            check("err_missing", cyc, exp_err[0]);
            void'(exp_err.pop_front());
        end
        if (err_ratio === 1'b1) begin
            if (exp_err.size() == 0) begin
                check("err_unexpected", int'(err_ratio), 0);
            end else begin
                check("err_cycle", cyc, exp_err[0]);
                if (exp_err[0] == cyc) void'(exp_err.pop_front());
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, a, r, b, hi, first;
        logic [5:0] pat;

        rst = 1'b1; run_en = 1'b0; cfg_valid = 1'b0; cfg_ratio = 8'h00;
        step(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        step(2);

        // Default ratio 16: LOAD cycle, then ticks every 16 with div_out 8 high / 8 low.
        run_en = 1'b1; t0 = cyc;
        exp_tick.push_back(t0 + 17);
        exp_tick.push_back(t0 + 33);
        step(1);
        check("load_pulse", load_pulse, 1);
        check("load_busy", busy, 1);
        check("load_cnt_dn", cnt_dn, 1);
        check("load_preset_hi", preset_hi, 4'h0);
        check("load_preset_lo", preset_lo, 4'hF);
        hi = 0; first = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (i == 0) first = div_out;
            hi += div_out;
        end
        check("div16_first_high", first, 1);
        check("div16_high_cycles", hi, 8);

        // Invalid ratio 1 while running: error pulse only.
        step(3);
        cfg_ratio = 8'd1; cfg_valid = 1'b1;
        exp_err.push_back(t0 + 21);
        step(1);
        cfg_valid = 1'b0;
        check("err_cfg_ready", cfg_ready, 1);
        step(1);
        check("err_ratio_kept", ratio_active, 16);
        check("err_cfg_ready_after", cfg_ready, 1);

        // Mid-period request for 3: old period completes, then swap.
        cfg_ratio = 8'd3; cfg_valid = 1'b1;
        exp_tick.push_back(t0 + 36);
        exp_tick.push_back(t0 + 39);
        exp_tick.push_back(t0 + 42);
        exp_tick.push_back(t0 + 58);
        step(1);
        cfg_valid = 1'b0;
        check("pend_cfg_ready", cfg_ready, 0);
        check("pend_ratio_old", ratio_active, 16);
        step(10);
        check("swap_load_pulse", load_pulse, 1);
        check("swap_preset_hi", preset_hi, 4'h0);
        check("swap_preset_lo", preset_lo, 4'h2);
        check("swap_cfg_ready", cfg_ready, 0);
        step(1);
        check("swap_ratio_new", ratio_active, 3);
        check("swap_cfg_ready_back", cfg_ready, 1);

        // Request for 16 in the same cycle as terminal count: reload keeps ratio 3.
        step(5);
        cfg_ratio = 8'd16; cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        check("tc_xfer_ratio_old", ratio_active, 3);
        check("tc_xfer_cfg_ready", cfg_ready, 0);

        // Stop at count 7: period completes, no reload, back to IDLE.
        step(11);
        run_en = 1'b0;
        step(7);
        check("stop_no_reload", load_pulse, 0);
        step(1);
        check("stop_busy", busy, 0);
        check("stop_div_out", div_out, 0);
        check("stop_cnt_dn", cnt_dn, 0);
        check("stop_cfg_ready", cfg_ready, 1);

        // IDLE configuration to 5: first tick 6 cycles after run_en, then every 5.
        cfg_ratio = 8'h05; cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        check("idle_ratio", ratio_active, 5);
        check("idle_preset_lo", preset_lo, 4);
        run_en = 1'b1; a = cyc;
        exp_tick.push_back(a + 6);
        exp_tick.push_back(a + 11);
        step(1);
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            hi += div_out;
        end
        check("div5_high_cycles", hi, 3);

        // Reset mid-period with a ratio pending.
        step(7);
        cfg_ratio = 8'd9; cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        check("pend2_cfg_ready", cfg_ready, 0);
        #3 rst = 1'b1; run_en = 1'b0;
        #1 check_reset_outputs("async_rst");
        step(3);
        rst = 1'b0;
        step(2);
        check_reset_outputs("post_rst");

        // Restart at the default ratio, then stop and run at the minimum ratio 2.
        run_en = 1'b1; r = cyc;
        exp_tick.push_back(r + 17);
        exp_tick.push_back(r + 33);
        exp_tick.push_back(r + 49);
        step(34);
        run_en = 1'b0;
        step(16);
        check("restart_stop_busy", busy, 0);
        cfg_ratio = 8'd2; cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        check("div2_ratio", ratio_active, 2);
        run_en = 1'b1; b = cyc;
        exp_tick.push_back(b + 3);
        exp_tick.push_back(b + 5);
        exp_tick.push_back(b + 7);
        step(1);
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            pat = {pat[4:0], div_out};
        end
        check("div2_pattern", pat, 6'b101010);
        run_en = 1'b0;
        step(3);

        check("tick_queue_drained", exp_tick.size(), 0);
        check("err_queue_drained", exp_err.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
